// File: rtl/vga_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sched_pkg
//  Description : Shared types and constants for the VGA pixel-pipe scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_sched_pkg;

    typedef enum logic [0:0] {
        PRIME = 1'b0,
        RUN   = 1'b1
    } sched_state_t;

    localparam int DIV_NORM = 4;
    localparam int DIV_X2   = 8;

    localparam int DEF_FIFO_AW = 4;
    localparam int DEF_LO_WM   = 8;
    localparam int DEF_HI_WM   = 14;
    localparam int DEF_MEM_LAT = 4;

endpackage
`default_nettype wire

// File: rtl/vga_pix_tick.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pix_tick
//  Description : 3-bit pixel-rate divider; divide select is sampled at wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_pix_tick
    import vga_sched_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic div_x2,
    output logic tick
);

    localparam logic [2:0] c_last_norm = 3'(DIV_NORM - 1);
    localparam logic [2:0] c_last_x2   = 3'(DIV_X2 - 1);

    logic [2:0] r_cnt;
    logic       r_div_x2;
    logic [2:0] w_last;
    logic       w_wrap;

    assign w_last = r_div_x2 ? c_last_x2 : c_last_norm;
    assign w_wrap = (r_cnt == w_last);
    assign tick   = ~clr & w_wrap;

    // While cleared the select keeps tracking the input, so the first period
    // after release already uses the current divide setting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= 3'd0;
            r_div_x2 <= 1'b0;
        end else if (clr || w_wrap) begin
            r_cnt    <= 3'd0;
            r_div_x2 <= div_x2;
        end else begin
            r_cnt    <= r_cnt + 3'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_pipe_sched.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pipe_sched
//  Description : Front-end advance / FIFO read pacing scheduler for the VGA
//                pixel pipe, with fill hysteresis and underflow detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_pipe_sched
    import vga_sched_pkg::*;
#(
    parameter int FIFO_AW = DEF_FIFO_AW,
    parameter int LO_WM   = DEF_LO_WM,
    parameter int HI_WM   = DEF_HI_WM,
    parameter int MEM_LAT = DEF_MEM_LAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x_dotclockdiv2,
    input  logic [FIFO_AW:0] fifo_nword,
    input  logic             seq_stb_i,
    input  logic             clr_underflow,
    output logic             advance_o,
    output logic             csr_stb_o,
    output logic             read_fifo_o,
    output logic             pal_dac_en_o,
    output logic             primed_o,
    output logic             underflow_o
);

    localparam logic [FIFO_AW:0] c_lo_wm = (FIFO_AW + 1)'(LO_WM);
    localparam logic [FIFO_AW:0] c_hi_wm = (FIFO_AW + 1)'(HI_WM);
    localparam logic [FIFO_AW:0] c_full  = {1'b1, {FIFO_AW{1'b0}}};

    sched_state_t     r_state;
    sched_state_t     w_state_next;
    logic             r_fill_on;
    logic             w_fill_next;
    logic [MEM_LAT-1:0] r_mem_p;
    logic [MEM_LAT-1:0] w_mem_shift;
    logic             r_read;
    logic             r_underflow;

    logic             w_run;
    logic             w_tick;
    logic             w_nword_zero;
    logic             w_above_hi;
    logic             w_uf_evt;
    logic             w_fill_eff;
    logic             w_mem_active;
    logic             w_full_hold;
    logic             w_advance;
    logic             w_csr;

    assign w_run        = (r_state == RUN);
    assign w_nword_zero = (fifo_nword == '0);
    assign w_above_hi   = (fifo_nword >= c_hi_wm);
    assign w_uf_evt     = w_run & w_tick & w_nword_zero;

    vga_pix_tick u_pix_tick (
        .clk    (clk),
        .rst    (rst),
        .clr    (~w_run),
        .div_x2 (x_dotclockdiv2),
        .tick   (w_tick)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= PRIME;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            PRIME:   if (w_above_hi) w_state_next = RUN;
            RUN:     if (w_uf_evt)   w_state_next = PRIME;
            default: w_state_next = PRIME;
        endcase
    end

    // ------------------------------------------------------ fill / advance
    always_comb begin
        w_fill_next = r_fill_on;
        if (fifo_nword < c_lo_wm) begin
            w_fill_next = 1'b1;
        end else if (w_above_hi) begin
            w_fill_next = 1'b0;
        end
    end

    // A full FIFO may still be written on a cycle that also reads from it.
    assign w_fill_eff   = r_fill_on | ~w_run;
    assign w_mem_active = |r_mem_p;
    assign w_full_hold  = (fifo_nword == c_full) & ~r_read;
    assign w_advance    = (w_fill_eff | w_mem_active) & ~w_full_hold;
    assign w_csr        = seq_stb_i & w_advance;

    generate
        if (MEM_LAT == 1) begin : g_lat_one
            assign w_mem_shift = w_csr;
        end else begin : g_lat_multi
            assign w_mem_shift = {r_mem_p[MEM_LAT-2:0], w_csr};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill_on <= 1'b1;
            r_mem_p   <= '0;
        end else begin
            r_fill_on <= w_fill_next;
            if (w_advance) begin
                r_mem_p <= w_mem_shift;
            end
        end
    end

    // ------------------------------------------------- read pacing / flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_read      <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_read <= w_run & w_tick & ~w_nword_zero;
            if (w_uf_evt) begin
                r_underflow <= 1'b1;
            end else if (clr_underflow) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign advance_o    = w_advance;
    assign csr_stb_o    = w_csr;
    assign read_fifo_o  = r_read;
    assign pal_dac_en_o = r_read;
    assign primed_o     = w_run;
    assign underflow_o  = r_underflow;

endmodule
`default_nettype wire
